vtg_frame_ctrl: RTL

//  Video timing/frame sequencer that drives the scaler input stream (di/de/hs/vs) in simulation and on hardware.

---
 rtl/vtg_frame_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/vtg_frame_ctrl.sv
// Video timing/frame sequencer: programmable active/blank sizes, gradient test
// pattern, multi-frame runs with start/stop control and a done pulse.
module vtg_frame_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 12,
    parameter int FRM_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CNT_WIDTH-1:0]  cfg_xsize_i,
    input  logic [CNT_WIDTH-1:0]  cfg_ysize_i,
    input  logic [CNT_WIDTH-1:0]  cfg_hblank_i,
    input  logic [CNT_WIDTH-1:0]  cfg_vblank_i,
    input  logic [FRM_WIDTH-1:0]  cfg_nframe_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [FRM_WIDTH-1:0]  frcnt_o,
    output logic [DATA_WIDTH-1:0] do_o,
    output logic                  de_o,
    output logic                  hs_o,
    output logic                  vs_o
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_HBLANK = 2'd2;
    localparam logic [1:0] S_VBLANK = 2'd3;
    // Position counters are one bit wider so xsize+hblank never overflows.
    localparam int PW = CNT_WIDTH + 1;

    logic [1:0]            state_q, state_d;
    logic [PW-1:0]         x_q, x_d, y_q, y_d;
    logic [CNT_WIDTH-1:0]  xs_q, xs_d, ys_q, ys_d, hb_q, hb_d, vb_q, vb_d;
    logic [FRM_WIDTH-1:0]  nf_q, nf_d, frcnt_q, frcnt_d;
    logic                  stop_pend_q, stop_pend_d;
    logic                  busy_q, busy_d, done_q, done_d;
    logic                  de_q, de_d, hs_q, hs_d, vs_q, vs_d;
    logic [DATA_WIDTH-1:0] do_q, do_d;

    logic [PW-1:0] htot, vtot;
    logic          act_end, line_end, frm_end;

    function automatic logic [CNT_WIDTH-1:0] clamp1(input logic [CNT_WIDTH-1:0] v);
        return (v == '0) ? CNT_WIDTH'(1) : v;
    endfunction

    assign htot     = {1'b0, xs_q} + {1'b0, hb_q};
    assign vtot     = {1'b0, ys_q} + {1'b0, vb_q};
    assign act_end  = (x_q == {1'b0, xs_q} - PW'(1));
    assign line_end = (x_q == htot - PW'(1));

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        xs_d        = xs_q;
        ys_d        = ys_q;
        hb_d        = hb_q;
        vb_d        = vb_q;
        nf_d        = nf_q;
        frcnt_d     = frcnt_q;
        stop_pend_d = stop_pend_q;
        done_d      = 1'b0;
        frm_end     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d     = S_ACTIVE;
                    x_d         = '0;
                    y_d         = '0;
                    frcnt_d     = '0;
                    stop_pend_d = stop_i;
                    xs_d        = clamp1(cfg_xsize_i);
                    ys_d        = clamp1(cfg_ysize_i);
                    hb_d        = clamp1(cfg_hblank_i);
                    vb_d        = clamp1(cfg_vblank_i);
                    nf_d        = cfg_nframe_i;
                end
            end
            S_ACTIVE: begin
                x_d = x_q + PW'(1);
                if (act_end) state_d = S_HBLANK;
            end
            S_HBLANK: begin
                if (line_end) begin
                    x_d     = '0;
                    y_d     = y_q + PW'(1);
                    state_d = (y_q == {1'b0, ys_q} - PW'(1)) ? S_VBLANK : S_ACTIVE;
                end else begin
                    x_d = x_q + PW'(1);
                end
            end
            S_VBLANK: begin
                if (line_end) begin
                    x_d = '0;
                    if (y_q == vtot - PW'(1)) frm_end = 1'b1;
                    else                      y_d = y_q + PW'(1);
                end else begin
                    x_d = x_q + PW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && stop_i) stop_pend_d = 1'b1;

        if (frm_end) begin
            frcnt_d = frcnt_q + FRM_WIDTH'(1);
            if ((nf_q != '0 && frcnt_d == nf_q) || stop_pend_d) begin
                state_d     = S_IDLE;
                done_d      = 1'b1;
                stop_pend_d = 1'b0;
            end else begin
                state_d = S_ACTIVE;
                y_d     = '0;
            end
        end

        // Outputs are registered from the next-state view of the sequencer.
        busy_d = (state_d != S_IDLE);
        de_d   = (state_d == S_ACTIVE);
        vs_d   = (state_d == S_VBLANK);
        hs_d   = (state_d == S_HBLANK) || (state_d == S_VBLANK && x_d >= {1'b0, xs_q});
        do_d   = de_d ? (DATA_WIDTH'(x_d) + DATA_WIDTH'(y_d) + DATA_WIDTH'(frcnt_d)) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            xs_q        <= '0;
            ys_q        <= '0;
            hb_q        <= '0;
            vb_q        <= '0;
            nf_q        <= '0;
            frcnt_q     <= '0;
            stop_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            de_q        <= 1'b0;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            do_q        <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            xs_q        <= xs_d;
            ys_q        <= ys_d;
            hb_q        <= hb_d;
            vb_q        <= vb_d;
            nf_q        <= nf_d;
            frcnt_q     <= frcnt_d;
            stop_pend_q <= stop_pend_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            de_q        <= de_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            do_q        <= do_d;
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign frcnt_o = frcnt_q;
    assign do_o    = do_q;
    assign de_o    = de_q;
    assign hs_o    = hs_q;
    assign vs_o    = vs_q;
endmodule
